// File: rtl/fractal_colorizer.sv
// fractal_colorizer
// Maps the fractal generator's 8-bit iteration-count stream through a
// programmable 256 x 24-bit RGB palette and buffers the result in a
// first-word-fall-through FIFO that drives an AXI4-Stream video output.
// The input has no backpressure. On overrun the block drops whole frames.
// After a drop it only restarts at the next frame-start pixel.
//
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   in_data/in_frame_start/in_line_end/in_valid
//                             pixel input (count, tuser, tlast, tvalid)
//   pal_we/pal_addr/pal_wdata palette write port, entry = {R,G,B}
//   overflow_clr              clears the sticky overflow flag
//   m_axis_t*                 AXI4-Stream RGB output (tuser = frame start,
//                             tlast = line end)
//   overflow                  sticky flag: a pixel was dropped in RUN
//   fifo_level                current FIFO occupancy
module fractal_colorizer #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  in_data,
  input  logic                        in_frame_start,
  input  logic                        in_line_end,
  input  logic                        in_valid,
  input  logic                        pal_we,
  input  logic [7:0]                  pal_addr,
  input  logic [23:0]                 pal_wdata,
  input  logic                        overflow_clr,
  output logic [23:0]                 m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RESYNC = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    init_cnt_r;
  logic [23:0]   pal_mem_r [256];
  logic [23:0]   pal_rdata_r;
  logic          s1_valid_r, s1_user_r, s1_last_r;
  logic [25:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          overflow_r;

  logic [LW-1:0] space_s;
  logic          has_space_s, accept_s, drop_run_s, push_s, pop_s;
  logic          pal_wen_s;
  logic [7:0]    pal_waddr_s;
  logic [23:0]   pal_wdat_s;
  logic [25:0]   head_s;

  // Space counts the pixel still in stage 1; a pop in this cycle earns no credit.
  assign space_s     = DEPTH_L - level_r - (s1_valid_r ? LVL_ONE : {LW{1'b0}});
  assign has_space_s = (space_s != {LW{1'b0}});

  // Next-state, accept/drop decision and palette write-port muxing.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    drop_run_s  = 1'b0;
    pal_wen_s   = pal_we;
    pal_waddr_s = pal_addr;
    pal_wdat_s  = pal_wdata;
    case (state_r)
      ST_INIT: begin
        // Grayscale fill owns the write port; user writes are ignored.
        pal_wen_s   = 1'b1;
        pal_waddr_s = init_cnt_r;
        pal_wdat_s  = {init_cnt_r, init_cnt_r, init_cnt_r};
        if (init_cnt_r == 8'd255) begin
          state_s = ST_RESYNC;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RESYNC: begin
        if (in_valid && in_frame_start && has_space_s) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_RESYNC;
        end
      end
      ST_RUN: begin
        if (in_valid && has_space_s) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else if (in_valid) begin
          drop_run_s = 1'b1;
          state_s    = ST_RESYNC;
        end else begin
          state_s    = ST_RUN;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // State register and grayscale init counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_INIT;
      init_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      init_cnt_r <= (state_r == ST_INIT) ? (init_cnt_r + 8'd1) : 8'd0;
    end
  end

  // Palette RAM: read-first synchronous read, contents survive reset.
  always_ff @(posedge clk) begin
    if (pal_wen_s) begin
      pal_mem_r[pal_waddr_s] <= pal_wdat_s;
    end
    pal_rdata_r <= pal_mem_r[in_data];
  end

  // Stage 1: flags travel alongside the palette read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_r <= 1'b0;
      s1_user_r  <= 1'b0;
      s1_last_r  <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      s1_user_r  <= in_frame_start;
      s1_last_r  <= in_line_end;
    end
  end

  assign push_s = s1_valid_r;
  assign pop_s  = m_axis_tvalid && m_axis_tready;

  // Stage 2: FIFO storage write.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {s1_user_r, s1_last_r, pal_rdata_r};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky overflow: a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_r <= 1'b0;
    end else if (drop_run_s) begin
      overflow_r <= 1'b1;
    end else if (overflow_clr) begin
      overflow_r <= 1'b0;
    end
  end

  // Outputs are gated by the registered occupancy, so the reset drops them at once.
  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign m_axis_tvalid = (level_r != {LW{1'b0}});
  assign m_axis_tdata  = m_axis_tvalid ? head_s[23:0] : 24'd0;
  assign m_axis_tlast  = m_axis_tvalid ? head_s[24]   : 1'b0;
  assign m_axis_tuser  = m_axis_tvalid ? head_s[25]   : 1'b0;
  assign overflow      = overflow_r;
  assign fifo_level    = level_r;

endmodule

// File: tb/tb_fractal_colorizer.sv
module tb_fractal_colorizer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_frame_start, in_line_end, in_valid;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic        overflow_clr;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic        overflow;
  logic [3:0]  fifo_level;

  int checks = 0;
  int failures = 0;

  logic [25:0] obs_q[$];
  logic [25:0] exp_q[$];

  typedef struct {
    logic [7:0]  d;
    logic        fs;
    logic        le;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[12];

  fractal_colorizer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .in_data(in_data), .in_frame_start(in_frame_start),
    .in_line_end(in_line_end), .in_valid(in_valid),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .overflow_clr(overflow_clr),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted output beats half a cycle before the edge that pops them.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      obs_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic fs, input logic le);
    in_valid       = v;
    in_data        = d;
    in_frame_start = fs;
    in_line_end    = le;
  endtask

  task automatic drain(input string name);
    m_axis_tready = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (fifo_level == 4'd0 && !dut.s1_valid_r) break;
      tick();
    end
    tick();
    chk(name, {28'd0, fifo_level}, 32'd0);
  endtask

  task automatic compare_queues(input string name);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) chk(name, {6'd0, obs_q[i]}, {6'd0, exp_q[i]});
    end
  endtask

  // Release reset with frame-start pixels every cycle; only the pixel of cycle 257 may be first.
  task automatic run_init(input logic [7:0] d, input logic [23:0] exp_rgb);
    int first_e;
    logic [25:0] first_beat;
    logic ovf_seen;
    first_e    = 0;
    first_beat = 26'd0;
    ovf_seen   = 1'b0;
    m_axis_tready = 1'b1;
    pal_we = 1'b1;
    pal_addr = d;
    pal_wdata = 24'h123456;
    @(negedge clk);
    #1;
    resetn = 1'b1;
    for (int e = 1; e <= 262; e++) begin
      drive(1'b1, (e == 257) ? d : 8'hC3, 1'b1, 1'b0);
      tick();
      if (m_axis_tvalid && first_e == 0) begin
        first_e    = e;
        first_beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      end
      ovf_seen = ovf_seen | overflow;
    end
    pal_we = 1'b0;
    chk("init_first_valid_edge", first_e, 32'd258);
    chk("init_first_beat", {6'd0, first_beat}, {6'd0, 2'b10, exp_rgb});
    chk("init_overflow", {31'd0, ovf_seen}, 32'd0);
    drain("init_drain");
  endtask

  initial begin
    logic [25:0] head_exp;
    int unstable;
    logic [7:0] d;

    resetn = 1'b1;
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    pal_we = 1'b0; pal_addr = 8'h00; pal_wdata = 24'h0;
    overflow_clr = 1'b0;
    m_axis_tready = 1'b1;

    // Vector table: a 4x2 frame through reprogrammed entry 0x10, then a grayscale line.
    for (int i = 0; i < 8; i++) begin
      tbl[i].d   = 8'h10;
      tbl[i].fs  = (i == 0);
      tbl[i].le  = (i % 4 == 3);
      tbl[i].rgb = 24'hFF8000;
    end
    tbl[8]  = '{8'h00, 1'b1, 1'b0, 24'h000000};
    tbl[9]  = '{8'hFF, 1'b0, 1'b0, 24'hFFFFFF};
    tbl[10] = '{8'h5A, 1'b0, 1'b0, 24'h5A5A5A};
    tbl[11] = '{8'h81, 1'b0, 1'b1, 24'h818181};

    #1 resetn = 1'b0;
    #2;
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_outs", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 32'd0);

    // Reset / INIT.
    run_init(8'h37, 24'h373737);

    // Palette write then table-driven stream.
    pal_we = 1'b1; pal_addr = 8'h10; pal_wdata = 24'hFF8000;
    tick();
    pal_we = 1'b0;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].d, tbl[i].fs, tbl[i].le);
      exp_q.push_back({tbl[i].fs, tbl[i].le, tbl[i].rgb});
      tick();
    end
    drain("pal_drain");
    compare_queues("pal_beat");

    // Read-first: write and read of 0x20 in the same cycle.
    obs_q.delete(); exp_q.delete();
    pal_we = 1'b1; pal_addr = 8'h20; pal_wdata = 24'h00FF00;
    drive(1'b1, 8'h20, 1'b1, 1'b0);
    tick();
    pal_we = 1'b0;
    drive(1'b1, 8'h20, 1'b0, 1'b1);
    tick();
    exp_q.push_back({2'b10, 24'h202020});
    exp_q.push_back({2'b01, 24'h00FF00});
    drain("rf_drain");
    compare_queues("rf_beat");

    // Backpressure: 7 pixels held with tready low.
    obs_q.delete(); exp_q.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      d = 8'(i + 1);
      drive(1'b1, d, (i == 0), (i == 6));
      exp_q.push_back({(i == 0), (i == 6), d, d, d});
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    chk("bp_level", {28'd0, fifo_level}, 32'd7);
    head_exp = {2'b10, 24'h010101};
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      if (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== head_exp) unstable++;
      tick();
    end
    chk("bp_stable", unstable, 32'd0);
    chk("bp_overflow", {31'd0, overflow}, 32'd0);
    drain("bp_drain");
    compare_queues("bp_beat");

    // Overflow / resync: three 4x4 frames, tready low during frame 0.
    obs_q.delete(); exp_q.delete();
    m_axis_tready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 16; p++) begin
        d = 8'(8'h40 + f * 16 + p);
        if (f == 1 && p == 0) m_axis_tready = 1'b1;
        drive(1'b1, d, (p == 0), (p % 4 == 3));
        if ((f == 0 && p < 8) || f == 2) exp_q.push_back({(p == 0), (p % 4 == 3), d, d, d});
        tick();
        if (f == 0 && p == 7) chk("ovf_before_9th", {31'd0, overflow}, 32'd0);
        if (f == 0 && p == 8) chk("ovf_on_9th", {31'd0, overflow}, 32'd1);
        if (f == 0 && p == 15) chk("ovf_full_level", {28'd0, fifo_level}, 32'd8);
      end
    end
    drain("ovf_drain");
    compare_queues("ovf_beat");
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clear", {31'd0, overflow}, 32'd0);

    // Reset mid-stream with 5 pixels buffered.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h10, (i == 0), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    chk("mid_level_before", {28'd0, fifo_level}, 32'd5);
    resetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("mid_rst_level", {28'd0, fifo_level}, 32'd0);
    // Entry 0x10 was 0xFF8000; the re-run INIT must restore grayscale.
    run_init(8'h10, 24'h101010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
